// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: op encodings,
// FSM states and the access-width helpers.
package data_mem_responder_pkg;

    localparam logic [3:0] MEM_LB  = 4'h0;
    localparam logic [3:0] MEM_LH  = 4'h1;
    localparam logic [3:0] MEM_LW  = 4'h2;
    localparam logic [3:0] MEM_LBU = 4'h4;
    localparam logic [3:0] MEM_LHU = 4'h5;
    localparam logic [3:0] MEM_SB  = 4'h8;
    localparam logic [3:0] MEM_SH  = 4'h9;
    localparam logic [3:0] MEM_SW  = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } memState_t;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2,
        WIDTH_NONE = 2'd3
    } widthClass_t;

    function automatic widthClass_t widthOf(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: widthOf = WIDTH_BYTE;
            MEM_LH, MEM_LHU, MEM_SH: widthOf = WIDTH_HALF;
            MEM_LW, MEM_SW:          widthOf = WIDTH_WORD;
            default:                 widthOf = WIDTH_NONE;
        endcase
    endfunction

    function automatic logic isStoreOp(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic isLoadOp(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte/half/word lane merge for stores and sign/zero extension for loads.
// MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning them.
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addrLow,
    input  logic [31:0] oldWord,
    input  logic [31:0] wdata,
    output logic [31:0] mergedWord,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic [31:0] shiftedWord;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    assign shiftedWord = oldWord >> {addrLow, 3'b000};
    assign byteVal     = shiftedWord[7:0];
    assign halfVal     = addrLow[1] ? oldWord[31:16] : oldWord[15:0];

    always_comb begin
        mergedWord = oldWord;
        loadData   = 32'd0;
        misaligned = 1'b0;
        case (widthOf(op))
            WIDTH_BYTE: begin
                mergedWord[{addrLow, 3'b000} +: 8] = wdata[7:0];
                loadData = (op == MEM_LBU) ? {24'd0, byteVal} : {{24{byteVal[7]}}, byteVal};
            end
            WIDTH_HALF: begin
                // Only addr[1] selects the half, so addr[0] is implicitly forced to 0
                if (addrLow[1]) mergedWord[31:16] = wdata[15:0];
                else            mergedWord[15:0]  = wdata[15:0];
                loadData = (op == MEM_LHU) ? {16'd0, halfVal} : {{16{halfVal[15]}}, halfVal};
`ifdef MISALIGN_TRAP_EN
                misaligned = addrLow[0];
`endif
            end
            WIDTH_WORD: begin
                mergedWord = wdata;
                loadData   = oldWord;
`ifdef MISALIGN_TRAP_EN
                misaligned = (addrLow != 2'b00);
`endif
            end
            default: begin
                mergedWord = oldWord;
                loadData   = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: valid/ready request, WAIT_STATES wait cycles,
// registered valid/ready response. MISALIGN_TRAP_EN selects trapping on misalignment.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [3:0]  reqOpType,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWdata,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspRdata,
    output logic        rspErr
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [31:0] mem [DEPTH_WORDS];

    memState_t   stateReg, stateNext;
    logic [3:0]  cntReg, cntNext;
    logic        readyReg;
    logic        wrReg;
    logic [3:0]  opReg;
    logic [31:0] addrReg, wdataReg;
    logic [31:0] rdataReg;
    logic        errReg;

    logic        accept, goResp;
    logic        curWrite;
    logic [3:0]  curOp;
    logic [31:0] curAddr, curWdata;
    logic [AW-1:0] wordIdx;
    logic        outOfRange, dirBad, accessErr, memWe;
    logic [31:0] oldWord, mergedWord, extData;
    logic        misaligned;

    assign accept = (stateReg == ST_IDLE) && readyReg && reqValid;

    // With zero wait states the access commits on the accepting edge, so decode live inputs
    assign curWrite = (stateReg == ST_IDLE) ? reqWrite  : wrReg;
    assign curOp    = (stateReg == ST_IDLE) ? reqOpType : opReg;
    assign curAddr  = (stateReg == ST_IDLE) ? reqAddr   : addrReg;
    assign curWdata = (stateReg == ST_IDLE) ? reqWdata  : wdataReg;

    assign wordIdx    = curAddr[AW+1:2];
    assign outOfRange = |curAddr[31:AW+2];
    assign dirBad     = curWrite ? !isStoreOp(curOp) : !isLoadOp(curOp);
    assign oldWord    = mem[wordIdx];

    mem_lane_align u_laneAlign (
        .op         (curOp),
        .addrLow    (curAddr[1:0]),
        .oldWord    (oldWord),
        .wdata      (curWdata),
        .mergedWord (mergedWord),
        .loadData   (extData),
        .misaligned (misaligned)
    );

    assign accessErr = outOfRange || dirBad || misaligned;
    assign memWe     = goResp && curWrite && !accessErr;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        goResp    = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        stateNext = ST_RESP;
                        goResp    = 1'b1;
                    end else begin
                        stateNext = ST_ACCESS;
                        cntNext   = WAIT_LOAD;
                    end
                end
            end
            ST_ACCESS: begin
                if (cntReg == 4'd0) begin
                    stateNext = ST_RESP;
                    goResp    = 1'b1;
                end else begin
                    cntNext = cntReg - 4'd1;
                end
            end
            ST_RESP: begin
                if (rspReady) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateReg <= ST_IDLE;
            cntReg   <= 4'd0;
            readyReg <= 1'b0;
            wrReg    <= 1'b0;
            opReg    <= 4'd0;
            addrReg  <= 32'd0;
            wdataReg <= 32'd0;
            rdataReg <= 32'd0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            readyReg <= (stateNext == ST_IDLE);
            if (accept) begin
                wrReg    <= reqWrite;
                opReg    <= reqOpType;
                addrReg  <= reqAddr;
                wdataReg <= reqWdata;
            end
            if (goResp) begin
                rdataReg <= (curWrite || accessErr) ? 32'd0 : extData;
                errReg   <= accessErr;
            end else if (stateReg == ST_RESP && rspReady) begin
                rdataReg <= 32'd0;
                errReg   <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; reset only blocks commits via the FSM
    always_ff @(posedge clk) begin
        if (memWe) mem[wordIdx] <= mergedWord;
    end

    assign reqReady = readyReg;
    assign rspValid = (stateReg == ST_RESP);
    assign rspRdata = rdataReg;
    assign rspErr   = errReg;

endmodule
